// File: rtl/id_hazard_unit.sv
// Decode-stage hazard controller: load-use stall, taken-branch flush,
// and saturating stall/flush performance counters.
module id_hazard_unit #(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned CNT_W             = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs1_ID,
  input  logic [4:0]       rs2_ID,
  input  logic             uses_rs1,
  input  logic             uses_rs2,
  input  logic             memRead_EX,
  input  logic             RegWrite_EX,
  input  logic [4:0]       targetReg_EX,
  input  logic             br_taken_EX,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             bubble_ID_EX,
  output logic             flush_IF_ID,
  output logic             stall_active,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [4:0] XZR = 5'd31;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

  state_t state, state_nxt;
  logic   rem, rem_nxt;
  logic   lu;
  logic   stall_inc, flush_inc;

  // Load in EX whose destination feeds a source actually read in ID.
  assign lu = memRead_EX & RegWrite_EX & (targetReg_EX != XZR) &
              ((uses_rs1 & (rs1_ID == targetReg_EX)) |
               (uses_rs2 & (rs2_ID == targetReg_EX)));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= RUN;
      rem   <= 1'b0;
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
    end
  end

  // Mealy next-state and front-end control.
  always_comb begin
    state_nxt    = state;
    rem_nxt      = rem;
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    bubble_ID_EX = 1'b0;
    flush_IF_ID  = 1'b0;
    stall_active = 1'b0;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;

    if (!reset) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      bubble_ID_EX = 1'b1;
      flush_IF_ID  = 1'b1;
      state_nxt    = RUN;
      rem_nxt      = 1'b0;
    end else if (br_taken_EX) begin
      // A redirect wins over any stall; younger instructions are squashed.
      flush_IF_ID  = 1'b1;
      bubble_ID_EX = 1'b1;
      flush_inc    = 1'b1;
      state_nxt    = RUN;
      rem_nxt      = 1'b0;
    end else if (state == STALL) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      bubble_ID_EX = 1'b1;
      stall_active = 1'b1;
      stall_inc    = 1'b1;
      if (rem) begin
        rem_nxt = 1'b0;
      end else begin
        state_nxt = RUN;
      end
    end else if (lu) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      bubble_ID_EX = 1'b1;
      stall_active = 1'b1;
      stall_inc    = 1'b1;
      if (LOAD_STALL_CYCLES == 2) begin
        state_nxt = STALL;
        rem_nxt   = 1'b0;
      end
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_inc && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_inc && (flush_cnt != CNT_MAX)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_hazard_unit.sv
// Directed bench for id_hazard_unit: one instance with 1-cycle stalls and
// 4-bit counters, one with 2-cycle stalls and 8-bit counters, sharing inputs.
module tb_id_hazard_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs1_ID, rs2_ID, targetReg_EX;
  logic       uses_rs1, uses_rs2, memRead_EX, RegWrite_EX, br_taken_EX;

  logic       a_pc, a_ifid, a_bub, a_fl, a_sa;
  logic [3:0] a_scnt, a_fcnt;
  logic       b_pc, b_ifid, b_bub, b_fl, b_sa;
  logic [7:0] b_scnt, b_fcnt;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  id_hazard_unit #(.LOAD_STALL_CYCLES(1), .CNT_W(4)) u1 (
    .clk(clk), .reset(reset), .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
    .uses_rs1(uses_rs1), .uses_rs2(uses_rs2), .memRead_EX(memRead_EX),
    .RegWrite_EX(RegWrite_EX), .targetReg_EX(targetReg_EX), .br_taken_EX(br_taken_EX),
    .pc_write(a_pc), .ifid_write(a_ifid), .bubble_ID_EX(a_bub), .flush_IF_ID(a_fl),
    .stall_active(a_sa), .stall_cnt(a_scnt), .flush_cnt(a_fcnt));

  id_hazard_unit #(.LOAD_STALL_CYCLES(2), .CNT_W(8)) u2 (
    .clk(clk), .reset(reset), .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
    .uses_rs1(uses_rs1), .uses_rs2(uses_rs2), .memRead_EX(memRead_EX),
    .RegWrite_EX(RegWrite_EX), .targetReg_EX(targetReg_EX), .br_taken_EX(br_taken_EX),
    .pc_write(b_pc), .ifid_write(b_ifid), .bubble_ID_EX(b_bub), .flush_IF_ID(b_fl),
    .stall_active(b_sa), .stall_cnt(b_scnt), .flush_cnt(b_fcnt));

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    rs1_ID = 5'd0; rs2_ID = 5'd0; targetReg_EX = 5'd0;
    uses_rs1 = 1'b0; uses_rs2 = 1'b0;
    memRead_EX = 1'b0; RegWrite_EX = 1'b0; br_taken_EX = 1'b0;
  endtask

  task automatic load_to(input logic [4:0] rd);
    memRead_EX = 1'b1; RegWrite_EX = 1'b1; targetReg_EX = rd;
  endtask

  task automatic do_reset();
    quiet();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    quiet();
    reset = 1'b0;
    @(negedge clk);
    vecs++;
    if ({a_pc, a_ifid, a_bub, a_fl, a_sa} !== 5'b00110) begin
      errs++; $display("FAIL reset_outs: got %b want 00110", {a_pc, a_ifid, a_bub, a_fl, a_sa});
    end
    tick();
    reset = 1'b1;
    @(negedge clk);
    vecs++;
    if (a_scnt !== 4'd0 || a_fcnt !== 4'd0 || b_scnt !== 8'd0 || b_fcnt !== 8'd0) begin
      errs++; $display("FAIL reset_cnt: got %0d/%0d/%0d/%0d want 0", a_scnt, a_fcnt, b_scnt, b_fcnt);
    end
    vecs++;
    if ({a_pc, a_ifid, a_bub, a_fl, a_sa} !== 5'b11000) begin
      errs++; $display("FAIL reset_run: got %b want 11000", {a_pc, a_ifid, a_bub, a_fl, a_sa});
    end
    tick();
  endtask

  task automatic test_lu_rs1();
    do_reset();
    load_to(5'd5); rs1_ID = 5'd5; uses_rs1 = 1'b1;
    @(negedge clk);
    vecs++;
    if ({a_pc, a_ifid, a_bub, a_fl, a_sa} !== 5'b00101) begin
      errs++; $display("FAIL lu_rs1_detect: got %b want 00101", {a_pc, a_ifid, a_bub, a_fl, a_sa});
    end
    tick();
    memRead_EX = 1'b0;
    @(negedge clk);
    vecs++;
    if ({a_pc, a_ifid, a_bub, a_sa} !== 4'b1100 || a_scnt !== 4'd1) begin
      errs++; $display("FAIL lu_rs1_release: got %b cnt %0d want 1100 cnt 1", {a_pc, a_ifid, a_bub, a_sa}, a_scnt);
    end
    tick();
  endtask

  task automatic test_no_hazard();
    do_reset();
    load_to(5'd31); rs2_ID = 5'd31; uses_rs2 = 1'b1;
    @(negedge clk);
    vecs++;
    if (a_bub !== 1'b0 || a_pc !== 1'b1 || b_bub !== 1'b0) begin
      errs++; $display("FAIL xzr: got bub %b pc %b bub2 %b want 0 1 0", a_bub, a_pc, b_bub);
    end
    tick();
    targetReg_EX = 5'd5; rs2_ID = 5'd5; uses_rs2 = 1'b0;
    @(negedge clk);
    vecs++;
    if (a_bub !== 1'b0 || a_pc !== 1'b1 || a_scnt !== 4'd0) begin
      errs++; $display("FAIL unused_rs2: got bub %b pc %b cnt %0d want 0 1 0", a_bub, a_pc, a_scnt);
    end
    tick();
    uses_rs2 = 1'b1; RegWrite_EX = 1'b0;
    @(negedge clk);
    vecs++;
    if (a_bub !== 1'b0 || a_scnt !== 4'd0 || b_scnt !== 8'd0) begin
      errs++; $display("FAIL no_regwrite: got bub %b cnt %0d/%0d want 0 0/0", a_bub, a_scnt, b_scnt);
    end
    tick();
  endtask

  task automatic test_two_cycle_stall();
    do_reset();
    load_to(5'd7); rs2_ID = 5'd7; uses_rs2 = 1'b1;
    @(negedge clk);
    vecs++;
    if ({b_pc, b_ifid, b_bub, b_fl, b_sa} !== 5'b00101) begin
      errs++; $display("FAIL lsc2_first: got %b want 00101", {b_pc, b_ifid, b_bub, b_fl, b_sa});
    end
    tick();
    memRead_EX = 1'b0;
    @(negedge clk);
    vecs++;
    if ({b_pc, b_ifid, b_bub, b_fl, b_sa} !== 5'b00101 || b_scnt !== 8'd1) begin
      errs++; $display("FAIL lsc2_second: got %b cnt %0d want 00101 cnt 1", {b_pc, b_ifid, b_bub, b_fl, b_sa}, b_scnt);
    end
    tick();
    @(negedge clk);
    vecs++;
    if ({b_pc, b_ifid, b_bub, b_sa} !== 4'b1100 || b_scnt !== 8'd2 || a_scnt !== 4'd1) begin
      errs++; $display("FAIL lsc2_release: got %b cnt %0d cnt1 %0d want 1100 cnt 2 cnt1 1", {b_pc, b_ifid, b_bub, b_sa}, b_scnt, a_scnt);
    end
    tick();
  endtask

  task automatic test_branch_priority();
    do_reset();
    load_to(5'd5); rs1_ID = 5'd5; uses_rs1 = 1'b1; br_taken_EX = 1'b1;
    @(negedge clk);
    vecs++;
    if ({a_pc, a_ifid, a_bub, a_fl, a_sa} !== 5'b11110 || {b_pc, b_bub, b_fl} !== 3'b111) begin
      errs++; $display("FAIL br_lu: got %b / %b want 11110 / 111", {a_pc, a_ifid, a_bub, a_fl, a_sa}, {b_pc, b_bub, b_fl});
    end
    tick();
    quiet();
    @(negedge clk);
    vecs++;
    if (a_fcnt !== 4'd1 || a_scnt !== 4'd0 || b_fcnt !== 8'd1 || b_scnt !== 8'd0 || b_pc !== 1'b1) begin
      errs++; $display("FAIL br_cnt: got f%0d s%0d f%0d s%0d pc %b want f1 s0 f1 s0 pc 1", a_fcnt, a_scnt, b_fcnt, b_scnt, b_pc);
    end
    tick();
  endtask

  task automatic test_reset_in_stall();
    do_reset();
    load_to(5'd9); rs1_ID = 5'd9; uses_rs1 = 1'b1;
    tick();
    quiet();
    reset = 1'b0;
    @(negedge clk);
    vecs++;
    if ({b_pc, b_ifid, b_bub, b_fl, b_sa} !== 5'b00110) begin
      errs++; $display("FAIL rst_stall_outs: got %b want 00110", {b_pc, b_ifid, b_bub, b_fl, b_sa});
    end
    tick();
    reset = 1'b1;
    @(negedge clk);
    vecs++;
    if ({b_pc, b_ifid, b_bub, b_sa} !== 4'b1100 || b_scnt !== 8'd0 || b_fcnt !== 8'd0) begin
      errs++; $display("FAIL rst_stall_run: got %b cnt %0d/%0d want 1100 cnt 0/0", {b_pc, b_ifid, b_bub, b_sa}, b_scnt, b_fcnt);
    end
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    load_to(5'd4); rs1_ID = 5'd4; uses_rs1 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) begin
        @(negedge clk);
        vecs++;
        if (a_scnt !== 4'd10) begin
          errs++; $display("FAIL sat_mid: got %0d want 10", a_scnt);
        end
      end
      tick();
    end
    quiet();
    @(negedge clk);
    vecs++;
    if (a_scnt !== 4'd15) begin
      errs++; $display("FAIL sat_cap: got %0d want 15", a_scnt);
    end
    vecs++;
    if (b_scnt !== 8'd20) begin
      errs++; $display("FAIL sat_wide: got %0d want 20", b_scnt);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    load_to(5'd3); rs1_ID = 5'd5; uses_rs1 = 1'b1;
    @(negedge clk);
    tick();
    targetReg_EX = 5'd6;
    @(negedge clk);
    vecs++;
    if (a_bub !== 1'b0 || a_pc !== 1'b1 || b_bub !== 1'b0) begin
      errs++; $display("FAIL indep_loads: got bub %b pc %b bub2 %b want 0 1 0", a_bub, a_pc, b_bub);
    end
    tick();
    targetReg_EX = 5'd5;
    @(negedge clk);
    vecs++;
    if (a_bub !== 1'b1 || a_pc !== 1'b0) begin
      errs++; $display("FAIL dep_first: got bub %b pc %b want 1 0", a_bub, a_pc);
    end
    tick();
    memRead_EX = 1'b0;
    tick();
    memRead_EX = 1'b1;
    @(negedge clk);
    vecs++;
    if (a_bub !== 1'b1 || a_sa !== 1'b1 || a_scnt !== 4'd1) begin
      errs++; $display("FAIL dep_redetect: got bub %b sa %b cnt %0d want 1 1 1", a_bub, a_sa, a_scnt);
    end
    tick();
    quiet();
    @(negedge clk);
    vecs++;
    if (a_scnt !== 4'd2 || a_pc !== 1'b1) begin
      errs++; $display("FAIL dep_count: got cnt %0d pc %b want 2 1", a_scnt, a_pc);
    end
    tick();
  endtask

  initial begin
    quiet();
    reset = 1'b0;
    tick();
    test_reset();
    test_lu_rs1();
    test_no_hazard();
    test_two_cycle_stall();
    test_branch_priority();
    test_reset_in_stall();
    test_saturation();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
